vga_serializer: RTL and testbench

//  Display-side counterpart of the capture shifter. Capture packs 8 serial pixels per byte and requests a store (save/saved).

---
 rtl/vga_serializer.sv | 110 +++++++++++
 tb/tb_vga_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_serializer.sv
// vga_serializer: fetches pixel bytes over a fetch/fetched handshake, shifts them out as 1-bit video and generates VGA syncs
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   fetch             request for the next byte (held until fetched)
//   fetched           one-cycle strobe, fetch_data valid this cycle
//   fetch_data        byte, bit7 is the earliest pixel
//   sol, sof          one-cycle pulses when an active line's fetch window opens (sof for line 0)
//   video             registered serial pixel, 0 in blanking
//   hsync, vsync      registered sync outputs, SYNC_POL when asserted
//   underrun          one-cycle pulse when a load slot finds the buffer empty
module vga_serializer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fetch,
  input  logic       fetched,
  input  logic [7:0] fetch_data,
  output logic       sol,
  output logic       sof,
  output logic       video,
  output logic       hsync,
  output logic       vsync,
  output logic       underrun
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int NB = H_ACTIVE / 8;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(NB + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_OPEN = HW'(H_TOTAL - 9);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] B_LAST = CW'(NB - 1);
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt, next_line;
  logic [CW-1:0] bcnt;
  logic [7:0] buf_q, sr, sr_next;
  logic buf_valid, fetch_en;
  logic h_wrap, win_open, active, load, take, hs_raw, vs_raw;
  assign fetch = fetch_en & ~buf_valid & ~rst;
  always_comb begin
    h_wrap    = hcnt == H_LAST;
    next_line = vcnt == V_LAST ? '0 : vcnt + VW'(1);
    // decided one cycle early so the window (sol, fetch) is visible while hcnt == H_TOTAL-8
    win_open  = hcnt == H_OPEN && next_line < V_ACT;
    active    = vcnt < V_ACT && hcnt < H_ACT;
    load      = active && hcnt[2:0] == 3'd0;
    take      = fetched && fetch;
    sr_next   = load ? (buf_valid ? buf_q : 8'h00) : {sr[6:0], 1'b0};
    hs_raw    = hcnt >= HS_BEG && hcnt < HS_END;
    vs_raw    = vcnt >= VS_BEG && vcnt < VS_END;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt      <= '0;
      vcnt      <= V_LAST;
      bcnt      <= '0;
      buf_q     <= '0;
      buf_valid <= 1'b0;
      fetch_en  <= 1'b0;
      sr        <= '0;
      video     <= 1'b0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      sol       <= 1'b0;
      sof       <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      hcnt     <= h_wrap ? '0 : hcnt + HW'(1);
      vcnt     <= h_wrap ? next_line : vcnt;
      sol      <= win_open;
      sof      <= win_open && next_line == '0;
      underrun <= load && !buf_valid;
      sr       <= active ? sr_next : sr;
      video    <= active && sr_next[7];
      hsync    <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync    <= vs_raw ? SYNC_POL : ~SYNC_POL;
      if (win_open) begin
        // any byte left over from the previous line is dropped here
        bcnt      <= '0;
        buf_valid <= 1'b0;
        fetch_en  <= 1'b1;
      end else begin
        // a refill in a load cycle keeps the buffer full; the load took the old byte
        buf_valid <= take ? 1'b1 : load ? 1'b0 : buf_valid;
        if (take) begin
          buf_q <= fetch_data;
          bcnt  <= bcnt + CW'(1);
          if (bcnt == B_LAST) fetch_en <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_serializer.sv
// tb_vga_serializer: directed checks of the small-config and default-config serializer
module tb_vga_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, fetch, fetched, sol, sof, video, hsync, vsync, underrun;
  logic [7:0] fetch_data;
  logic d_rst = 1'b1, d_fetch, d_fetched, d_sol, d_sof, d_video, d_hsync, d_vsync, d_underrun;
  logic [7:0] d_fetch_data;
  int errors = 0, checks = 0, lat = 0;
  logic [7:0] bytes [0:7] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h42, 8'h18, 8'h24};
  logic vid [0:199], hs [0:199], vs [0:199], sl [0:199], sf [0:199], ur [0:199], fe [0:199];

  vga_serializer #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(8),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .fetched(fetched), .fetch_data(fetch_data),
    .sol(sol), .sof(sof), .video(video), .hsync(hsync), .vsync(vsync), .underrun(underrun));

  vga_serializer dflt (
    .clk(clk), .rst(d_rst), .fetch(d_fetch), .fetched(d_fetched), .fetch_data(d_fetch_data),
    .sol(d_sol), .sof(d_sof), .video(d_video), .hsync(d_hsync), .vsync(d_vsync), .underrun(d_underrun));

  // small-config memory: answers lat cycles after fetch rises (0 = same cycle)
  initial begin
    int idx, wcnt;
    idx = 0; wcnt = 0; fetched = 1'b0; fetch_data = 8'h00;
    forever begin
      @(posedge clk); #3;
      fetched = 1'b0;
      if (rst) begin
        idx = 0; wcnt = 0;
      end else if (fetch) begin
        if (wcnt == lat) begin
          fetched = 1'b1; fetch_data = bytes[idx % 8]; idx++; wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial begin
    d_fetched = 1'b0; d_fetch_data = 8'h55;
    forever begin
      @(posedge clk); #3;
      d_fetched = d_fetch;
    end
  end

  // sample index t counts edges after the reset edge; sample t shows the state while hcnt = t mod 30
  task automatic capture(input int l, input int n);
    lat = l;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (t > 0) begin @(posedge clk); #2; end else #1;
      vid[t] = video; hs[t] = hsync; vs[t] = vsync; sl[t] = sol; sf[t] = sof; ur[t] = underrun; fe[t] = fetch;
    end
  endtask

  task automatic test_reset;
    capture(0, 4);
    checks++; if (vid[0] !== 1'b0) begin errors++; $display("FAIL reset_video: got %b expected 0", vid[0]); end
    checks++; if (hs[0] !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hs[0]); end
    checks++; if (vs[0] !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vs[0]); end
    checks++; if ({sl[0], sf[0], ur[0]} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b%b%b expected 000", sl[0], sf[0], ur[0]); end
    checks++; if (fe[0] !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b expected 0", fe[0]); end
  endtask

  task automatic check_lines(input string tag, input logic [15:0] e0, input logic [15:0] e1, input int e_ur);
    logic [15:0] l0, l1;
    int ones, nur;
    ones = 0; nur = 0;
    for (int i = 0; i < 16; i++) begin
      l0 = {l0[14:0], vid[31 + i]};
      l1 = {l1[14:0], vid[61 + i]};
    end
    for (int t = 1; t < 160; t++) begin
      if (!((t >= 31 && t <= 46) || (t >= 61 && t <= 76)) && vid[t]) ones++;
      if (ur[t]) nur++;
    end
    checks++; if (l0 !== e0) begin errors++; $display("FAIL %s_line0: got %h expected %h", tag, l0, e0); end
    checks++; if (l1 !== e1) begin errors++; $display("FAIL %s_line1: got %h expected %h", tag, l1, e1); end
    checks++; if (ones !== 0) begin errors++; $display("FAIL %s_blank_video: got %0d ones expected 0", tag, ones); end
    checks++; if (nur !== e_ur) begin errors++; $display("FAIL %s_underruns: got %0d expected %0d", tag, nur, e_ur); end
  endtask

  task automatic test_pixels;
    capture(0, 160);
    check_lines("lat0", 16'hA53C, 16'hFF00, 0);
  endtask

  task automatic test_sync;
    int hlow, vlow, nsol, nsof;
    capture(0, 160);
    hlow = 0; vlow = 0; nsol = 0; nsof = 0;
    for (int t = 1; t <= 30; t++) if (!hs[t]) hlow++;
    for (int t = 1; t < 160; t++) begin
      if (!vs[t]) vlow++;
      if (sl[t]) nsol++;
      if (sf[t]) nsof++;
    end
    checks++; if ({hs[18], hs[19], hs[22], hs[23]} !== 4'b1001) begin errors++; $display("FAIL hsync_edges: got %b%b%b%b expected 1001", hs[18], hs[19], hs[22], hs[23]); end
    checks++; if (hlow !== 4) begin errors++; $display("FAIL hsync_width: got %0d expected 4", hlow); end
    checks++; if ({vs[120], vs[121], vs[150], vs[151]} !== 4'b1001) begin errors++; $display("FAIL vsync_edges: got %b%b%b%b expected 1001", vs[120], vs[121], vs[150], vs[151]); end
    checks++; if (vlow !== 30) begin errors++; $display("FAIL vsync_width: got %0d expected 30", vlow); end
    checks++; if ({sl[22], sf[22], sl[52], sf[52]} !== 4'b1110) begin errors++; $display("FAIL sol_sof_pos: got %b%b%b%b expected 1110", sl[22], sf[22], sl[52], sf[52]); end
    checks++; if (nsol !== 2 || nsof !== 1) begin errors++; $display("FAIL sol_sof_count: got %0d/%0d expected 2/1", nsol, nsof); end
  endtask

  task automatic test_latency;
    capture(6, 160);
    check_lines("lat6", 16'hA53C, 16'hFF00, 0);
    capture(7, 160);
    checks++; if ({ur[38], ur[39], ur[40]} !== 3'b010) begin errors++; $display("FAIL lat7_underrun_slot: got %b%b%b expected 010", ur[38], ur[39], ur[40]); end
    check_lines("lat7", 16'hA500, 16'hFF00, 2);
  endtask

  task automatic test_reset_midline;
    int t, k;
    logic found;
    lat = 3;
    capture(3, 1);
    found = 1'b0;
    for (t = 1; t < 100 && !found; t++) begin
      @(posedge clk); #2;
      if (fetch && t > 30) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midline_wait_fetch: got no fetch within 100 clks expected fetch=1"); end
    rst = 1'b1; #1;
    checks++; if (fetch !== 1'b0) begin errors++; $display("FAIL midline_fetch_gate: got %b expected 0", fetch); end
    @(posedge clk); #1 rst = 1'b0; #1;
    checks++; if ({video, hsync, vsync, sol, underrun, fetch} !== 6'b011000) begin errors++; $display("FAIL midline_reset_state: got %b%b%b%b%b%b expected 011000", video, hsync, vsync, sol, underrun, fetch); end
    k = 0; found = 1'b0;
    while (k < 40 && !found) begin
      @(posedge clk); #2; k++;
      if (sol) found = 1'b1;
    end
    checks++; if (k !== 22) begin errors++; $display("FAIL midline_first_sol: got %0d clks expected 22", k); end
    repeat (9) @(posedge clk);
    #2;
    checks++; if (video !== 1'b1) begin errors++; $display("FAIL midline_pixel0: got %b expected 1", video); end
    @(posedge clk); #2;
    checks++; if (video !== 1'b0) begin errors++; $display("FAIL midline_pixel1: got %b expected 0", video); end
  endtask

  task automatic test_default_timing;
    int pre, nf, vlow, f1, f2;
    logic prev;
    pre = 0; nf = 0; vlow = 0; f1 = -1; f2 = -1;
    @(posedge clk); #1 d_rst = 1'b1;
    @(posedge clk); #1 d_rst = 1'b0; #1;
    prev = d_hsync;
    for (int t = 1; t < 1592; t++) begin
      @(posedge clk); #2;
      if (d_fetch) begin
        if (t < 792) pre++; else nf++;
      end
      if (!d_vsync) vlow++;
      if (prev && !d_hsync) begin
        if (f1 < 0) f1 = t; else if (f2 < 0) f2 = t;
      end
      prev = d_hsync;
    end
    checks++; if (pre !== 0) begin errors++; $display("FAIL dflt_vblank_fetches: got %0d expected 0", pre); end
    checks++; if (nf !== 80) begin errors++; $display("FAIL dflt_line_fetches: got %0d expected 80", nf); end
    checks++; if (f1 !== 657) begin errors++; $display("FAIL dflt_hsync_first: got %0d expected 657", f1); end
    checks++; if (f2 - f1 !== 800) begin errors++; $display("FAIL dflt_hsync_period: got %0d expected 800", f2 - f1); end
    checks++; if (vlow !== 0) begin errors++; $display("FAIL dflt_vsync_idle: got %0d low clks expected 0", vlow); end
  endtask

  initial begin
    test_reset;
    test_pixels;
    test_sync;
    test_latency;
    test_reset_midline;
    test_default_timing;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
